// File: rtl/rom_arbiter_if.sv
// Bundle of the fetch port, load port and combinational ROM lookup
// shared between the arbiter and its requesters.
interface rom_arbiter_if;
    logic        if_req;
    logic [11:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        ls_req;
    logic [11:0] ls_addr;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic [11:0] rom_addr;
    logic [31:0] rom_inst;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, rom_inst,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, rom_inst,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a combinational code ROM: fetch has priority,
// loads win after STARVE_MAX consecutive fetch grants while they wait.
module rom_arbiter #(
    parameter int DEPTH      = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_arbiter_if.slave bus
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          if_gnt, ls_gnt;
    logic          addr_ok;

    logic          if_rvalid_q, if_rvalid_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_err_q, if_err_d;
    logic          ls_rvalid_q, ls_rvalid_d;
    logic [31:0]   ls_rdata_q, ls_rdata_d;
    logic          ls_err_q, ls_err_d;

    function automatic logic addr_valid(input logic [11:0] a);
        return (a[1:0] == 2'b00) && ({22'd0, a[11:2]} < 32'(DEPTH));
    endfunction

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (bus.ls_req && (!bus.if_req || starve_cnt_q == CNT_MAX)) begin
            ls_gnt = 1'b1;
        end else if (bus.if_req) begin
            if_gnt = 1'b1;
        end
    end

    // The counter only measures an unbroken wait: any gap in ls_req restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.ls_req || ls_gnt) begin
            starve_cnt_d = '0;
        end else if (if_gnt && starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    assign bus.rom_addr = ls_gnt ? bus.ls_addr : bus.if_addr;
    assign addr_ok      = addr_valid(bus.rom_addr);

    always_comb begin
        if_rvalid_d = if_gnt;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        ls_rvalid_d = ls_gnt;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = ls_err_q;
        if (if_gnt) begin
            if_rdata_d = addr_ok ? bus.rom_inst : 32'd0;
            if_err_d   = !addr_ok;
        end
        if (ls_gnt) begin
            ls_rdata_d = addr_ok ? bus.rom_inst : 32'd0;
            ls_err_d   = !addr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= 32'd0;
            if_err_q     <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            ls_rdata_q   <= 32'd0;
            ls_err_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            if_err_q     <= if_err_d;
            ls_rvalid_q  <= ls_rvalid_d;
            ls_rdata_q   <= ls_rdata_d;
            ls_err_q     <= ls_err_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_err    = ls_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: a driver checks grants against a rule
// model and queues expected responses; a monitor pops and compares them.
module tb_rom_arbiter;

    localparam int DEPTH      = 128;
    localparam int STARVE_MAX = 4;

    typedef struct {
        int unsigned stamp;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    rom_arbiter_if bus ();

    logic [31:0] rom_mem [0:1023];
    resp_t       if_q [$];
    resp_t       ls_q [$];

    int unsigned cyc          = 0;
    int          checks       = 0;
    int          errors       = 0;
    int          ls_wait_wins = 0;

    logic [31:0] last_if_data = 32'd0;
    logic [31:0] last_ls_data = 32'd0;
    logic        last_if_err  = 1'b0;
    logic        last_ls_err  = 1'b0;

    rom_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_inst = rom_mem[bus.rom_addr[11:2]];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic addr_bad(input logic [11:0] a);
        return (a % 4 != 0) || (int'(a) / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] exp_word(input logic [11:0] a);
        if (addr_bad(a)) return 32'd0;
        return rom_mem[int'(a) / 4];
    endfunction

    function automatic logic [11:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 12'($urandom_range(0, 4095));
        if (r == 1) return 12'($urandom_range(DEPTH, 1023) * 4);
        return 12'($urandom_range(0, DEPTH - 1) * 4);
    endfunction

    // Drive one cycle of requests, check the combinational grant against the
    // priority rules, and queue the response the granted port should see.
    task automatic apply_stimulus(input logic ifr, input logic [11:0] ifa,
                                  input logic lsr, input logic [11:0] lsa);
        logic  e_ls, e_if;
        resp_t r;
        @(negedge clk);
        bus.if_req  = ifr;
        bus.if_addr = ifa;
        bus.ls_req  = lsr;
        bus.ls_addr = lsa;
        #1;
        e_ls = lsr && (!ifr || ls_wait_wins >= STARVE_MAX);
        e_if = ifr && !e_ls;
        check_output("if_gnt", 32'(bus.if_gnt), 32'(e_if));
        check_output("ls_gnt", 32'(bus.ls_gnt), 32'(e_ls));
        check_output("rom_addr", 32'(bus.rom_addr), 32'(e_ls ? lsa : ifa));
        if (e_if) begin
            r.stamp = cyc + 1;
            r.data  = exp_word(ifa);
            r.err   = addr_bad(ifa);
            if_q.push_back(r);
        end
        if (e_ls) begin
            r.stamp = cyc + 1;
            r.data  = exp_word(lsa);
            r.err   = addr_bad(lsa);
            ls_q.push_back(r);
        end
        if (!lsr || e_ls) ls_wait_wins = 0;
        else if (e_if && ls_wait_wins < STARVE_MAX) ls_wait_wins++;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        check_output("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        check_output("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
        check_output("rst_if_rdata", bus.if_rdata, 32'd0);
        check_output("rst_ls_rdata", bus.ls_rdata, 32'd0);
        check_output("rst_if_err", 32'(bus.if_err), 32'd0);
        check_output("rst_ls_err", 32'(bus.ls_err), 32'd0);
        if_q.delete();
        ls_q.delete();
        ls_wait_wins = 0;
        last_if_data = 32'd0;
        last_ls_data = 32'd0;
        last_if_err  = 1'b0;
        last_ls_err  = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic monitor_port(input bit is_ls, input logic rv, input logic [31:0] rd, input logic er);
        resp_t e;
        bit    have;
        string p;
        p    = is_ls ? "ls" : "if";
        have = is_ls ? (ls_q.size() > 0) : (if_q.size() > 0);
        if (have) e = is_ls ? ls_q[0] : if_q[0];
        if (rv) begin
            if (!have) begin
                check_output({p, "_spurious_rvalid"}, 32'(rv), 32'd0);
            end else begin
                check_output({p, "_latency"}, cyc, e.stamp);
                check_output({p, "_rdata"}, rd, e.data);
                check_output({p, "_err"}, 32'(er), 32'(e.err));
                if (is_ls) begin
                    void'(ls_q.pop_front());
                    last_ls_data = e.data;
                    last_ls_err  = e.err;
                end else begin
                    void'(if_q.pop_front());
                    last_if_data = e.data;
                    last_if_err  = e.err;
                end
            end
        end else if (have && e.stamp <= cyc) begin
            check_output({p, "_rvalid"}, 32'(rv), 32'd1);
            if (is_ls) void'(ls_q.pop_front());
            else void'(if_q.pop_front());
        end else begin
            check_output({p, "_hold_rdata"}, rd, is_ls ? last_ls_data : last_if_data);
            check_output({p, "_hold_err"}, 32'(er), 32'(is_ls ? last_ls_err : last_if_err));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                check_output("rstcyc_if_rvalid", 32'(bus.if_rvalid), 32'd0);
                check_output("rstcyc_ls_rvalid", 32'(bus.ls_rvalid), 32'd0);
                check_output("rstcyc_if_rdata", bus.if_rdata, 32'd0);
                check_output("rstcyc_ls_rdata", bus.ls_rdata, 32'd0);
            end else begin
                monitor_port(1'b0, bus.if_rvalid, bus.if_rdata, bus.if_err);
                monitor_port(1'b1, bus.ls_rvalid, bus.ls_rdata, bus.ls_err);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
        rom_mem[0]  = 32'h0000_0293;
        bus.if_req  = 1'b0;
        bus.if_addr = 12'd0;
        bus.ls_req  = 1'b0;
        bus.ls_addr = 12'd0;
        #1;
        do_reset(2);

        apply_stimulus(1'b1, 12'h000, 1'b0, 12'h000);
        @(posedge clk);
        #2;
        check_output("first_fetch_rdata", bus.if_rdata, 32'h0000_0293);

        apply_stimulus(1'b1, 12'h000, 1'b0, 12'h000);
        apply_stimulus(1'b1, 12'h004, 1'b0, 12'h000);
        apply_stimulus(1'b1, 12'h008, 1'b0, 12'h000);
        apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000);

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b1, 12'(4 * (i % 8)), 1'b1, 12'(4 * ((i + 3) % 8)));
            check_output("starve_pattern_ls", 32'(bus.ls_gnt), 32'(i % 5 == 4));
        end

        apply_stimulus(1'b0, 12'h000, 1'b1, 12'h006);
        apply_stimulus(1'b0, 12'h000, 1'b1, 12'h200);
        apply_stimulus(1'b1, 12'h1FC, 1'b0, 12'h000);
        apply_stimulus(1'b0, 12'h000, 1'b1, 12'h1FC);
        apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000);
        apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 12'h010, 1'b1, 12'h020);
        apply_stimulus(1'b1, 12'h014, 1'b0, 12'h020);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 12'h018, 1'b1, 12'h024);
            check_output("restart_pattern_ls", 32'(bus.ls_gnt), 32'(i == 4));
        end

        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 12'h030, 1'b1, 12'h034);
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 12'h038, 1'b1, 12'h03C);
            check_output("post_reset_pattern_ls", 32'(bus.ls_gnt), 32'(i == 4));
        end

        apply_stimulus(1'b0, 12'h000, 1'b1, 12'h010);
        do_reset(2);
        apply_stimulus(1'b0, 12'h000, 1'b1, 12'h040);
        apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 3) != 0), rand_addr(),
                           1'($urandom_range(0, 1)), rand_addr());
        end
        apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000);
        apply_stimulus(1'b0, 12'h000, 1'b0, 12'h000);

        check_output("if_queue_drained", 32'(if_q.size()), 32'd0);
        check_output("ls_queue_drained", 32'(ls_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter DEPTH, default 128, number of 32-bit ROM words.
REQ-002 Parameter STARVE_MAX, default 4, consecutive fetch wins tolerated while a load waits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 if_req  input  1  fetch-port read request.
REQ-007 if_addr  input  12  fetch byte address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch response valid.
REQ-010 if_rdata  output  32  fetch response data.
REQ-011 if_err  output  1  fetch response is an error.
REQ-012 ls_req  input  1  load-port read request (lw from code space).
REQ-013 ls_addr  input  12  load byte address.
REQ-014 ls_gnt  output  1  load request accepted this cycle.
REQ-015 ls_rvalid  output  1  load response valid.
REQ-016 ls_rdata  output  32  load response data.
REQ-017 ls_err  output  1  load response is an error.
REQ-018 rom_addr  output  12  byte address to the combinational ROM.
REQ-019 rom_inst  input  32  combinational ROM word for rom_addr.

Function
REQ-020 At most one of if_gnt/ls_gnt SHALL be high per cycle; each is combinational from the requests and the priority state, with no added latency.
REQ-021 Default priority SHALL be fetch: if_req high, no load-priority override -> if_gnt=1, ls_gnt=0.
REQ-022 Starvation counter (width clog2(STARVE_MAX+1)): +1 on each cycle with if_gnt=1 and ls_req=1, saturating at STARVE_MAX; cleared on ls_gnt=1 or any cycle ls_req=0.
REQ-023 When counter == STARVE_MAX and ls_req=1, ls_gnt SHALL be 1 and if_gnt 0 that cycle.
REQ-024 ls_req alone -> ls_gnt=1; no requests -> both grants 0.
REQ-025 rom_addr SHALL equal the granted port's address; with no grant it equals if_addr.
REQ-026 Address valid iff addr[1:0]==0 and (addr>>2) < DEPTH.
REQ-027 A grant in cycle N SHALL produce exactly one response on the same port in cycle N+1: rvalid=1 for one cycle; rdata=rom_inst sampled at cycle-N edge, err=0 if valid; rdata=0, err=1 if invalid.
REQ-028 rvalid SHALL be 0 in cycles following no grant for that port; rdata/err SHALL hold their last values when rvalid=0.
REQ-029 Back-to-back grants on one port every cycle SHALL yield responses every cycle (full throughput, no bubbles).
REQ-030 A requester keeping req high without a grant SHALL not be required to hold its address; each cycle is evaluated independently.

Reset
REQ-031 rst_n low SHALL immediately force if_rvalid, ls_rvalid, if_err, ls_err = 0, if_rdata, ls_rdata = 0, starvation counter = 0.
REQ-032 Grants are combinational and not masked by reset; a response pending when rst_n asserts SHALL be dropped and not re-issued.
REQ-033 After rst_n deasserts, the first rising edge with a request SHALL behave as REQ-021..027.

Verification
REQ-034 ROM[0]=0x00000293, if_req=1, if_addr=0x000 -> if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0x00000293, if_err=0.
REQ-035 if_req, ls_req both high continuously, STARVE_MAX=4 -> grant pattern IF,IF,IF,IF,LS,IF,IF,IF,IF,LS...; each ls response one cycle after its ls_gnt.
REQ-036 ls_addr=0x006 -> ls_gnt=1; next cycle ls_rvalid=1, ls_err=1, ls_rdata=0; ls_addr=0x200 (word 128) -> same error response.
REQ-037 if_req streaming addresses 0x000,0x004,0x008 on consecutive cycles -> if_rvalid high three consecutive cycles with ROM[0],ROM[1],ROM[2].
REQ-038 Grant in cycle N, rst_n low in cycle N+1 before the edge -> no rvalid pulse; counter=0; after release, ls alone granted on first request.
REQ-039 ls_req drops after 3 fetch wins then reasserts -> counter restarted; load waits 4 fetch wins before priority.
